// File: rtl/board_io_ctrl.sv
// Board-side user-I/O controller: synchronises and debounces push-buttons and
// slide switches, latches sticky key-press events, and drives a bank of
// active-low seven-segment displays with blank, blink and leading-zero blanking.
module board_io_ctrl #(
  parameter int W_KEY           = 4,
  parameter int W_SW            = 18,
  parameter int N_HEX           = 8,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int BLINK_LOG2      = 24
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [W_KEY-1:0]     key_raw,
  input  logic [W_SW-1:0]      sw_raw,
  output logic [W_KEY-1:0]     key_pressed,
  output logic [W_SW-1:0]      sw_db,
  output logic [W_KEY-1:0]     key_event,
  input  logic [W_KEY-1:0]     event_clr,
  input  logic [4*N_HEX-1:0]   hex_value,
  input  logic [N_HEX-1:0]     hex_blank,
  input  logic [N_HEX-1:0]     hex_blink,
  input  logic                 lz_blank_en,
  output logic [7*N_HEX-1:0]   hex_seg
);

  // Keys and switches share one debounce datapath; keys occupy the low bits.
  localparam int W_IN  = W_KEY + W_SW;
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  // Idle pin levels: released buttons read high, switches start low.
  localparam logic [W_IN-1:0] SYNC_RST = {{W_SW{1'b0}}, {W_KEY{1'b1}}};

  // Active-low {g,f,e,d,c,b,a} pattern for one hex nibble.
  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

  logic [W_IN-1:0]  sync_p0;
  logic [W_IN-1:0]  sync_p1;
  logic [W_IN-1:0]  samp_p2;
  logic [W_IN-1:0]  db_out;
  logic [CNT_W-1:0] db_cnt [W_IN];
  logic [W_KEY-1:0] kp_prev;
  logic [BLINK_LOG2-1:0] pre_cnt;
  logic             blink_phase;
  logic [N_HEX-1:0] lz_dark;
  logic             zero_run;
  logic [7*N_HEX-1:0] seg_next;

  // Stage p0/p1: two-flop synchroniser; stage p2: polarity-normalised sample
  // (keys become active-high) that feeds the debounce comparators.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_p0 <= SYNC_RST;
      sync_p1 <= SYNC_RST;
      samp_p2 <= '0;
    end else begin
      sync_p0 <= {sw_raw, key_raw};
      sync_p1 <= sync_p0;
      samp_p2 <= {sync_p1[W_IN-1:W_KEY], ~sync_p1[W_KEY-1:0]};
    end
  end

  // Per-bit debounce: output follows the sample only after it has differed
  // for DEBOUNCE_CYCLES consecutive cycles; any agreement restarts the count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      db_out <= '0;
      for (int i = 0; i < W_IN; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < W_IN; i++) begin
        if (samp_p2[i] == db_out[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == CNT_LAST) begin
          db_out[i] <= samp_p2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  assign key_pressed = db_out[W_KEY-1:0];
  assign sw_db       = db_out[W_IN-1:W_KEY];

  // Sticky press events from a registered rising-edge detect; a new press
  // beats a simultaneous clear so no event is ever lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      kp_prev   <= '0;
      key_event <= '0;
    end else begin
      kp_prev   <= key_pressed;
      key_event <= (key_event & ~event_clr) | (key_pressed & ~kp_prev);
    end
  end

  // Free-running blink prescaler; its MSB is the blink phase.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) pre_cnt <= '0;
    else          pre_cnt <= pre_cnt + BLINK_LOG2'(1);
  end

  assign blink_phase = pre_cnt[BLINK_LOG2-1];

  // Leading-zero blanking looks only at nibble values, scanning from the top;
  // digit 0 always stays visible so a zero value still shows "0".
  always_comb begin
    lz_dark  = '0;
    zero_run = 1'b1;
    for (int i = N_HEX - 1; i >= 0; i--) begin
      zero_run   = zero_run & (hex_value[4*i +: 4] == 4'h0);
      lz_dark[i] = lz_blank_en & zero_run & (i != 0);
    end
  end

  // Per-digit segment selection: any dark condition overrides the decode.
  always_comb begin
    seg_next = '1;
    for (int i = 0; i < N_HEX; i++) begin
      if (hex_blank[i] | (hex_blink[i] & blink_phase) | lz_dark[i])
        seg_next[7*i +: 7] = 7'h7F;
      else
        seg_next[7*i +: 7] = seg_decode(hex_value[4*i +: 4]);
    end
  end

  // Registered display output, dark out of reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) hex_seg <= '1;
    else          hex_seg <= seg_next;
  end

endmodule

// File: tb/tb_board_io_ctrl.sv
// Directed bench for board_io_ctrl with a due-cycle scoreboard of expectations.
module tb_board_io_ctrl;

  localparam int W_KEY = 4;
  localparam int W_SW  = 18;
  localparam int N_HEX = 8;
  localparam int DB    = 8;
  localparam int BL    = 4;

  localparam logic [6:0] SEG_TBL [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                          7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  logic                 clk;
  logic                 reset_n;
  logic [W_KEY-1:0]     key_raw;
  logic [W_SW-1:0]      sw_raw;
  logic [W_KEY-1:0]     key_pressed;
  logic [W_SW-1:0]      sw_db;
  logic [W_KEY-1:0]     key_event;
  logic [W_KEY-1:0]     event_clr;
  logic [4*N_HEX-1:0]   hex_value;
  logic [N_HEX-1:0]     hex_blank;
  logic [N_HEX-1:0]     hex_blink;
  logic                 lz_blank_en;
  logic [7*N_HEX-1:0]   hex_seg;

  board_io_ctrl #(
    .W_KEY(W_KEY), .W_SW(W_SW), .N_HEX(N_HEX), .DEBOUNCE_CYCLES(DB), .BLINK_LOG2(BL)
  ) dut (
    .clk(clk), .reset_n(reset_n), .key_raw(key_raw), .sw_raw(sw_raw),
    .key_pressed(key_pressed), .sw_db(sw_db), .key_event(key_event),
    .event_clr(event_clr), .hex_value(hex_value), .hex_blank(hex_blank),
    .hex_blink(hex_blink), .lz_blank_en(lz_blank_en), .hex_seg(hex_seg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          due;
    int          sel;
    logic [55:0] exp;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   pre    = 0;

  function automatic logic [55:0] observe(input int sel);
    case (sel)
      0:       return 56'(key_pressed);
      1:       return 56'(sw_db);
      2:       return 56'(key_event);
      default: return hex_seg;
    endcase
  endfunction

  function automatic logic [55:0] hex_model(input logic [31:0] v, input logic [7:0] bl,
                                            input logic [7:0] bk, input logic lz, input logic ph);
    logic [55:0] r;
    logic [6:0]  d;
    logic [3:0]  nib;
    bit          seen_nz;
    r = '1;
    seen_nz = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      nib = v[4*i +: 4];
      if (nib != 4'h0) seen_nz = 1'b1;
      d = SEG_TBL[nib];
      if (bl[i] || (bk[i] && ph) || (lz && !seen_nz && i != 0)) d = 7'h7F;
      r[7*i +: 7] = d;
    end
    return r;
  endfunction

  task automatic check_now(input string tag, input logic [55:0] obs, input logic [55:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_at(input int dly, input int sel, input logic [55:0] e, input string tag);
    exp_t x;
    x.due = cyc + dly;
    x.sel = sel;
    x.exp = e;
    x.tag = tag;
    sb.push_back(x);
  endtask

  // One clock: advance, mirror the prescaler, then compare everything due now.
  task automatic step();
    @(posedge clk);
    cyc++;
    if (reset_n) pre = (pre + 1) % 16;
    @(negedge clk);
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due == cyc) begin
        check_now(sb[i].tag, observe(sb[i].sel), sb[i].exp);
        sb.delete(i);
      end
    end
  endtask

  task automatic set_hex(input logic [31:0] v, input logic [7:0] bl, input logic [7:0] bk, input logic lz);
    hex_value   = v;
    hex_blank   = bl;
    hex_blink   = bk;
    lz_blank_en = lz;
  endtask

  task automatic hex_drive(input logic [31:0] v, input logic [7:0] bl, input logic [7:0] bk, input logic lz);
    set_hex(v, bl, bk, lz);
    expect_at(1, 3, hex_model(v, bl, bk, lz, pre >= 8), "hex_model");
  endtask

  initial begin
    // Reset with random inputs
    reset_n     = 1'b1;
    key_raw     = 4'($urandom);
    sw_raw      = 18'($urandom);
    event_clr   = 4'($urandom);
    hex_value   = $urandom;
    hex_blank   = 8'($urandom);
    hex_blink   = 8'($urandom);
    lz_blank_en = 1'($urandom);
    #1 reset_n = 1'b0;
    repeat (3) step();
    check_now("rst_hex_dark", hex_seg, '1);
    check_now("rst_key_pressed", 56'(key_pressed), 56'd0);
    check_now("rst_key_event", 56'(key_event), 56'd0);
    check_now("rst_sw_db", 56'(sw_db), 56'd0);

    reset_n   = 1'b1;
    key_raw   = 4'hF;
    sw_raw    = '0;
    event_clr = '0;
    set_hex(32'h0, 8'h00, 8'h00, 1'b0);
    expect_at(1, 3, {8{7'h40}}, "hex_after_rst");
    repeat (3) step();

    // Key press latency and sticky event
    key_raw = 4'b1101;
    expect_at(10, 0, 56'h0, "kp1_early");
    expect_at(11, 0, 56'h2, "kp1_rise");
    expect_at(11, 2, 56'h0, "ev1_early");
    expect_at(12, 2, 56'h2, "ev1_set");
    repeat (20) step();
    key_raw = 4'hF;
    expect_at(10, 0, 56'h2, "kp1_rel_early");
    expect_at(11, 0, 56'h0, "kp1_released");
    expect_at(11, 2, 56'h2, "ev1_after_rel");
    expect_at(14, 2, 56'h2, "ev1_hold");
    repeat (15) step();

    // Short glitches must not reach the debounced outputs
    for (int k = 1; k <= 45; k++) begin
      expect_at(k, 0, 56'h0, "glitch_kp");
      expect_at(k, 1, 56'h0, "glitch_sw");
    end
    key_raw = 4'b1011;
    repeat (5) step();
    key_raw = 4'hF;
    for (int t = 0; t < 6; t++) begin
      sw_raw[0] = ~sw_raw[0];
      repeat (4) step();
    end
    repeat (16) step();

    // Switch pattern settles after the debounce latency
    sw_raw = 18'h2A5C3;
    expect_at(10, 1, 56'h0, "sw_early");
    expect_at(11, 1, 56'h2A5C3, "sw_settled");
    repeat (12) step();

    // Leading-zero blanking
    set_hex(32'h0000_00A5, 8'h00, 8'h00, 1'b1);
    expect_at(1, 3, {{6{7'h7F}}, 7'h08, 7'h12}, "lz_on");
    repeat (2) step();
    set_hex(32'h0000_00A5, 8'h00, 8'h00, 1'b0);
    expect_at(1, 3, {{6{7'h40}}, 7'h08, 7'h12}, "lz_off");
    repeat (2) step();
    set_hex(32'h0, 8'h00, 8'h00, 1'b1);
    expect_at(1, 3, {{7{7'h7F}}, 7'h40}, "lz_all_zero");
    step();
    set_hex(32'h0030_0000, 8'h20, 8'h00, 1'b1);
    expect_at(1, 3, {7'h7F, 7'h7F, 7'h7F, {5{7'h40}}}, "lz_vs_blank");
    step();
    hex_drive(32'h89BC_DEF1, 8'h00, 8'h00, 1'b1);
    step();
    hex_drive(32'h7654_3210, 8'h00, 8'h00, 1'b0);
    step();

    // Blink on digit 0, then forced blank on digit 1
    for (int k = 0; k < 32; k++) begin
      hex_drive(32'h0, 8'h00, 8'h01, 1'b0);
      step();
    end
    for (int k = 0; k < 16; k++) begin
      hex_drive(32'h0, 8'h02, 8'h01, 1'b0);
      step();
    end

    // Press beats a simultaneous clear; a lone clear takes effect
    key_raw = 4'b1101;
    expect_at(10, 0, 56'h0, "kp1_again_early");
    expect_at(11, 0, 56'h2, "kp1_again");
    repeat (11) step();
    event_clr = 4'b0010;
    expect_at(1, 2, 56'h2, "ev_set_wins");
    step();
    event_clr = 4'b0000;
    expect_at(1, 2, 56'h2, "ev_hold_after");
    step();
    event_clr = 4'b0010;
    expect_at(1, 2, 56'h0, "ev_cleared");
    step();
    event_clr = 4'b0000;
    key_raw = 4'hF;
    repeat (12) step();

    // Reset pulse part-way through a debounce count
    key_raw = 4'b0111;
    repeat (9) step();
    reset_n = 1'b0;
    pre = 0;
    #1;
    check_now("rst_async_hex", hex_seg, '1);
    check_now("rst_async_sw", 56'(sw_db), 56'h0);
    step();
    reset_n = 1'b1;
    expect_at(1, 0, 56'h0, "kp3_after_rst");
    expect_at(1, 2, 56'h0, "ev_after_rst");
    expect_at(10, 0, 56'h0, "kp3_recount_early");
    expect_at(11, 0, 56'h8, "kp3_recount");
    expect_at(12, 2, 56'h8, "ev3_set");
    repeat (13) step();

    check_now("scoreboard_drained", 56'(sb.size()), 56'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
